pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl_pkg.sv | 17 +
 rtl/pipeline_hazard_ctrl_fwd_match.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared scoreboard layout and constants for the hazard controller
package pipeline_hazard_ctrl_pkg;

    localparam int WORD_SIZE       = 16;
    localparam int FWD_SEL_REGFILE = 0;

    // Scoreboard entry bit layout: {rd, is_load, writes, valid}, rd occupies the top bits
    localparam int SB_VALID   = 0;
    localparam int SB_WRITES  = 1;
    localparam int SB_IS_LOAD = 2;
    localparam int SB_RD_LSB  = 3;

    function automatic int sb_entry_w(input int reg_addr_w);
        return SB_RD_LSB + reg_addr_w;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_match.sv
// rtl/pipeline_hazard_ctrl_fwd_match.sv - youngest-match forwarding priority encoder (module hazard_fwd_match)
module hazard_fwd_match #(
    parameter int PIPE_DEPTH = 3,
    parameter int REG_ADDR_W = 2,
    parameter int FWD_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic [PIPE_DEPTH*(3+REG_ADDR_W)-1:0] entries,
    input  logic [REG_ADDR_W-1:0]                src,
    input  logic                                 uses,
    output logic [FWD_W-1:0]                     sel
);
    import pipeline_hazard_ctrl_pkg::*;

    localparam int EW = SB_RD_LSB + REG_ADDR_W;

    logic [EW-1:0] ent;

    // Scan oldest to youngest so the youngest (smallest k) match overwrites last
    always_comb begin
        sel = FWD_W'(FWD_SEL_REGFILE);
        ent = '0;
        if (uses) begin
            for (int k = PIPE_DEPTH; k >= 1; k--) begin
                ent = entries[(k-1)*EW +: EW];
                if (ent[SB_VALID] && ent[SB_WRITES] && (ent[SB_RD_LSB +: REG_ADDR_W] == src)) begin
                    sel = FWD_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forwarding and retirement controller; optional HAZARD_PERF_EN counters
module pipeline_hazard_ctrl #(
    parameter int WORD_SIZE  = pipeline_hazard_ctrl_pkg::WORD_SIZE,
    parameter int REG_ADDR_W = 2,
    parameter int PIPE_DEPTH = 3,
    parameter int FWD_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_writes,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_is_load,
    input  logic                  id_is_halt,
    input  logic                  ex_branch_taken,
    input  logic                  mem_ready,
    output logic                  stall_if_id,
    output logic                  bubble_ex,
    output logic                  flush_if_id,
    output logic [FWD_W-1:0]      fwd_a_sel,
    output logic [FWD_W-1:0]      fwd_b_sel,
    output logic [WORD_SIZE-1:0]  num_inst,
    output logic                  is_halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [WORD_SIZE-1:0]  stall_cycles,
    output logic [WORD_SIZE-1:0]  flush_count
`endif
);
    import pipeline_hazard_ctrl_pkg::*;

    localparam int EW = SB_RD_LSB + REG_ADDR_W;

    logic [EW-1:0]            sb [PIPE_DEPTH];
    logic [PIPE_DEPTH*EW-1:0] sb_flat;
    logic [EW-1:0]            new_entry;
    logic                     halt_pending;
    logic                     load_use;
    logic                     issue;
    logic                     retire;
    logic                     older_empty;
    logic                     halt_retire;

    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_flat
        assign sb_flat[g*EW +: EW] = sb[g];
    end

    hazard_fwd_match #(
        .PIPE_DEPTH (PIPE_DEPTH),
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_W      (FWD_W)
    ) u_match_rs (
        .entries (sb_flat),
        .src     (id_rs),
        .uses    (id_uses_rs),
        .sel     (fwd_a_sel)
    );

    hazard_fwd_match #(
        .PIPE_DEPTH (PIPE_DEPTH),
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_W      (FWD_W)
    ) u_match_rt (
        .entries (sb_flat),
        .src     (id_rt),
        .uses    (id_uses_rt),
        .sel     (fwd_b_sel)
    );

    always_comb begin
        load_use = id_valid && sb[0][SB_IS_LOAD] &&
                   ((fwd_a_sel == FWD_W'(1)) || (fwd_b_sel == FWD_W'(1)));
        issue    = id_valid && mem_ready && !ex_branch_taken && !load_use && !halt_pending;

        new_entry                            = '0;
        new_entry[SB_VALID]                  = 1'b1;
        new_entry[SB_WRITES]                 = id_writes;
        new_entry[SB_IS_LOAD]                = id_is_load;
        new_entry[SB_RD_LSB +: REG_ADDR_W]   = id_rd;

        retire      = sb[PIPE_DEPTH-1][SB_VALID];
        older_empty = 1'b1;
        for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
            if (sb[i][SB_VALID]) begin
                older_empty = 1'b0;
            end
        end
        // Nothing issues behind HLT, so HLT is the retiring entry once it is the only one left
        halt_retire = mem_ready && halt_pending && retire && older_empty;
    end

    // Priority: memory freeze, then branch flush, then halt/load-use stall
    always_comb begin
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        if (!mem_ready) begin
            stall_if_id = 1'b1;
        end else if (ex_branch_taken) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end else if (halt_pending || load_use) begin
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sb[i] <= '0;
            end
            num_inst     <= '0;
            halt_pending <= 1'b0;
            is_halted    <= 1'b0;
        end else if (mem_ready) begin
            sb[0] <= issue ? new_entry : '0;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                sb[i] <= sb[i-1];
            end
            if (retire) begin
                num_inst <= num_inst + WORD_SIZE'(1);
            end
            if (issue && id_is_halt) begin
                halt_pending <= 1'b1;
            end
            if (halt_retire) begin
                is_halted <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_if_id && !halt_pending && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + WORD_SIZE'(1);
            end
            if (flush_if_id && (flush_count != '1)) begin
                flush_count <= flush_count + WORD_SIZE'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - vector table, hand sequences and randomized reference-model check
module tb_pipeline_hazard_ctrl;

    localparam int D = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid, id_uses_rs, id_uses_rt, id_writes, id_is_load, id_is_halt;
    logic [1:0] id_rs, id_rt, id_rd;
    logic       ex_branch_taken, mem_ready;
    logic       stall_if_id, bubble_ex, flush_if_id;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [15:0] num_inst;
    logic       is_halted;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_writes       (id_writes),
        .id_rd           (id_rd),
        .id_is_load      (id_is_load),
        .id_is_halt      (id_is_halt),
        .ex_branch_taken (ex_branch_taken),
        .mem_ready       (mem_ready),
        .stall_if_id     (stall_if_id),
        .bubble_ex       (bubble_ex),
        .flush_if_id     (flush_if_id),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .num_inst        (num_inst),
        .is_halted       (is_halted)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic mr, br, iv, urs, urt, wr, ld, hl;
        logic [1:0] rs, rt, rd;
        logic e_stall, e_bub, e_flush;
        int   e_fa, e_fb, e_num;
    } vec_t;

    vec_t tbl [13];

    // Reference model: in-flight instruction records, index 1 = EX
    bit       m_v [1:D];
    bit       m_w [1:D];
    bit       m_ld[1:D];
    bit       m_h [1:D];
    bit [1:0] m_rd[1:D];
    int       m_num;
    bit       m_hp, m_halted;

    function automatic int msel(input bit uses, input bit [1:0] src);
        if (!uses) return 0;
        for (int k = 1; k <= D; k++)
            if (m_v[k] && m_w[k] && m_rd[k] == src) return k;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 1; k <= D; k++) begin
            m_v[k] = 0; m_w[k] = 0; m_ld[k] = 0; m_h[k] = 0; m_rd[k] = 0;
        end
        m_num = 0; m_hp = 0; m_halted = 0;
    endtask

    task automatic drive(input logic mr, br, iv, urs, urt, wr, ld, hl,
                         input logic [1:0] rs, rt, rd);
        mem_ready = mr; ex_branch_taken = br; id_valid = iv;
        id_uses_rs = urs; id_uses_rt = urt; id_writes = wr;
        id_is_load = ld; id_is_halt = hl; id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic random_cycle(input int cyc);
        bit mr, br, iv, urs, urt, wr, ld, hl;
        bit [1:0] rs, rt, rd;
        int fa, fb, e_st, e_bu, e_fl;
        bit lu, iss;
        mr  = ($urandom_range(0, 9) != 0);
        br  = ($urandom_range(0, 9) == 0);
        iv  = ($urandom_range(0, 9) < 8);
        urs = $urandom_range(0, 1);
        urt = $urandom_range(0, 1);
        wr  = $urandom_range(0, 1);
        ld  = wr && ($urandom_range(0, 2) == 0);
        hl  = ($urandom_range(0, 59) == 0);
        rs  = 2'($urandom_range(0, 3));
        rt  = 2'($urandom_range(0, 3));
        rd  = 2'($urandom_range(0, 3));
        drive(mr, br, iv, urs, urt, wr, ld, hl, rs, rt, rd);

        fa = msel(urs, rs);
        fb = msel(urt, rt);
        lu = iv && m_ld[1] && (fa == 1 || fb == 1);
        e_st = 0; e_bu = 0; e_fl = 0;
        if (!mr) e_st = 1;
        else if (br) begin e_fl = 1; e_bu = 1; end
        else if (m_hp || lu) begin e_st = 1; e_bu = 1; end
        iss = iv && mr && !br && !lu && !m_hp;

        #1;
        check($sformatf("rnd%0d fwd_a", cyc), 32'(fwd_a_sel), 32'(fa));
        check($sformatf("rnd%0d fwd_b", cyc), 32'(fwd_b_sel), 32'(fb));
        check($sformatf("rnd%0d stall", cyc), 32'(stall_if_id), 32'(e_st));
        check($sformatf("rnd%0d bubble", cyc), 32'(bubble_ex), 32'(e_bu));
        check($sformatf("rnd%0d flush", cyc), 32'(flush_if_id), 32'(e_fl));
        check($sformatf("rnd%0d num_inst", cyc), 32'(num_inst), 32'(m_num & 16'hFFFF));
        check($sformatf("rnd%0d is_halted", cyc), 32'(is_halted), 32'(m_halted));

        if (mr) begin
            if (m_v[D]) begin
                m_num++;
                if (m_h[D]) m_halted = 1;
            end
            for (int k = D; k >= 2; k--) begin
                m_v[k] = m_v[k-1]; m_w[k] = m_w[k-1]; m_ld[k] = m_ld[k-1];
                m_h[k] = m_h[k-1]; m_rd[k] = m_rd[k-1];
            end
            m_v[1] = iss; m_w[1] = iss && wr; m_ld[1] = iss && ld;
            m_h[1] = iss && hl; m_rd[1] = rd;
            if (iss && hl) m_hp = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;
        int halted_for;
        //            mr br iv urs urt wr ld hl rs rt rd  st bu fl fa fb num
        tbl[0]  = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 3,  0, 0, 0, 1, 0, 0};
        tbl[2]  = '{1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 2, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 1, 0, 1, 1, 0, 0, 0, 2, 1,  1, 1, 0, 0, 1, 1};
        tbl[5]  = '{1, 0, 1, 0, 1, 1, 0, 0, 0, 2, 1,  0, 0, 0, 0, 2, 2};
        tbl[6]  = '{1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 2,  0, 0, 0, 0, 0, 3};
        tbl[7]  = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 2, 3,  0, 1, 1, 0, 1, 4};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4};
        tbl[9]  = '{0, 0, 1, 0, 1, 1, 0, 0, 0, 2, 1,  1, 0, 0, 0, 3, 5};
        tbl[10] = '{0, 0, 1, 0, 1, 1, 0, 0, 0, 2, 1,  1, 0, 0, 0, 3, 5};
        tbl[11] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0,  0, 0, 0, 0, 3, 5};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 6};

        reset_n = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check("reset stall", 32'(stall_if_id), 0);
        check("reset bubble", 32'(bubble_ex), 0);
        check("reset flush", 32'(flush_if_id), 0);
        check("reset fwd_a", 32'(fwd_a_sel), 0);
        check("reset fwd_b", 32'(fwd_b_sel), 0);
        check("reset num_inst", 32'(num_inst), 0);
        check("reset is_halted", 32'(is_halted), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].mr, tbl[i].br, tbl[i].iv, tbl[i].urs, tbl[i].urt, tbl[i].wr,
                  tbl[i].ld, tbl[i].hl, tbl[i].rs, tbl[i].rt, tbl[i].rd);
            #1;
            check($sformatf("vec%0d stall", i), 32'(stall_if_id), 32'(tbl[i].e_stall));
            check($sformatf("vec%0d bubble", i), 32'(bubble_ex), 32'(tbl[i].e_bub));
            check($sformatf("vec%0d flush", i), 32'(flush_if_id), 32'(tbl[i].e_flush));
            check($sformatf("vec%0d fwd_a", i), 32'(fwd_a_sel), 32'(tbl[i].e_fa));
            check($sformatf("vec%0d fwd_b", i), 32'(fwd_b_sel), 32'(tbl[i].e_fb));
            check($sformatf("vec%0d num_inst", i), 32'(num_inst), 32'(tbl[i].e_num));
            step();
        end

        // Five instructions then HLT
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'(i));
            step();
        end
        drive(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        step();
        drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        #1;
        check("halt pending stall", 32'(stall_if_id), 1);
        check("halt pending bubble", 32'(bubble_ex), 1);
        waited = 0;
        while (!is_halted && waited < 20) begin
            step();
            waited++;
        end
        check("halt reached in budget", 32'(is_halted), 1);
        check("halt num_inst", 32'(num_inst), 6);
        repeat (3) step();
        check("halt sticky", 32'(is_halted), 1);
        check("halt num stable", 32'(num_inst), 6);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset num_inst", 32'(num_inst), 0);
        check("async reset is_halted", 32'(is_halted), 0);
        check("async reset stall", 32'(stall_if_id), 0);
        reset_n = 1'b1;
        step();

        // Taken branch while HLT is in ID discards it
        do_reset();
        drive(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        check("br+hlt flush", 32'(flush_if_id), 1);
        step();
        drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        #1;
        check("br+hlt no pending stall", 32'(stall_if_id), 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
        check("br+hlt only one retire", 32'(num_inst), 1);
        check("br+hlt not halted", 32'(is_halted), 0);

        // Randomized against the reference model
        do_reset();
        halted_for = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_halted) halted_for++;
            if (halted_for > 4 || $urandom_range(0, 299) == 0) begin
                halted_for = 0;
                do_reset();
            end
            random_cycle(c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
